// File: rtl/sum_accum.sv
// Block accumulator: adds sum0+sum1 per accepted beat and emits one result per NUM_SAMPLES beats.
// Optional macro SUM_ACCUM_SAT_EN: accumulate adds saturate to all-ones instead of wrapping.
module sum_accum #(
  parameter int SW          = 9,
  parameter int NUM_SAMPLES = 4,
  parameter int AW          = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [SW-1:0] sum0,
  input  logic [SW-1:0] sum1,
  input  logic          clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_data,
  output logic          out_ovf
);

  localparam int CW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_SAMPLES - 1);

  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          ovf_acc;

  logic [SW:0]   bsum;
  logic [AW:0]   sum_ext;
  logic          carry;
  logic [AW-1:0] acc_next;
  logic          accept;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    bsum    = {1'b0, sum0} + {1'b0, sum1};
    sum_ext = {1'b0, acc} + (AW+1)'(bsum);
    carry   = sum_ext[AW];
`ifdef SUM_ACCUM_SAT_EN
    acc_next = carry ? '1 : sum_ext[AW-1:0];
`else
    acc_next = sum_ext[AW-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      ovf_acc   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      // handshake first so a same-cycle completion below re-asserts out_valid
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (clr) begin
        acc     <= '0;
        cnt     <= '0;
        ovf_acc <= 1'b0;
      end else if (accept) begin
        if (cnt == LAST) begin
          out_data  <= acc_next;
          out_ovf   <= ovf_acc | carry;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          ovf_acc   <= 1'b0;
        end else begin
          acc     <= acc_next;
          cnt     <= cnt + 1'b1;
          ovf_acc <= ovf_acc | carry;
        end
      end
    end
  end

endmodule

// File: tb/tb_sum_accum.sv
// Self-checking bench for sum_accum: three instances (4, 5 and 1 samples per block) share stimulus
// and are compared each cycle against an unbounded-integer block-sum model.
module tb_sum_accum;

  localparam int SW = 9;
  localparam int AW = 12;
  localparam int MAXV = (1 << AW) - 1;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n, in_valid, clr, out_ready;
  logic [SW-1:0] sum0, sum1;
  logic [NI-1:0] rdy, ov, ovf;
  logic [NI-1:0][AW-1:0] dat;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  int          ns [NI] = '{4, 5, 1};
  int unsigned m_sum [NI];
  int          m_cnt [NI];
  bit          m_ov  [NI];
  int unsigned m_dat [NI];
  bit          m_ovf [NI];

  always #5 clk = ~clk;

  sum_accum #(.SW(SW), .NUM_SAMPLES(4), .AW(AW)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .sum0(sum0), .sum1(sum1),
    .clr(clr), .out_valid(ov[0]), .out_ready(out_ready), .out_data(dat[0]), .out_ovf(ovf[0]));
  sum_accum #(.SW(SW), .NUM_SAMPLES(5), .AW(AW)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .sum0(sum0), .sum1(sum1),
    .clr(clr), .out_valid(ov[1]), .out_ready(out_ready), .out_data(dat[1]), .out_ovf(ovf[1]));
  sum_accum #(.SW(SW), .NUM_SAMPLES(1), .AW(AW)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .sum0(sum0), .sum1(sum1),
    .clr(clr), .out_valid(ov[2]), .out_ready(out_ready), .out_data(dat[2]), .out_ovf(ovf[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive, check in_ready, clock edge, advance model, check outputs.
  task automatic cycle(input bit v, input int a, input int b, input bit c, input bit ordy, input bit rn);
    bit acc_k [NI];
    in_valid = v; sum0 = SW'(a); sum1 = SW'(b); clr = c; out_ready = ordy; rst_n = rn;
    #1;
    for (int k = 0; k < NI; k++) begin
      bit r;
      r = !m_ov[k] || ordy;
      if (started) chk($sformatf("in_ready[%0d]", k), {31'd0, rdy[k]}, {31'd0, r});
      acc_k[k] = v && r;
    end
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      if (!rn) begin
        m_ov[k] = 0; m_dat[k] = 0; m_ovf[k] = 0; m_sum[k] = 0; m_cnt[k] = 0;
      end else begin
        if (m_ov[k] && ordy) m_ov[k] = 0;
        if (c) begin
          m_sum[k] = 0; m_cnt[k] = 0;
        end else if (acc_k[k]) begin
          m_sum[k] += a + b;
          m_cnt[k]++;
          if (m_cnt[k] == ns[k]) begin
            m_ov[k]  = 1;
`ifdef SUM_ACCUM_SAT_EN
            m_dat[k] = (m_sum[k] > MAXV) ? MAXV : m_sum[k];
`else
            m_dat[k] = m_sum[k] % (MAXV + 1);
`endif
            m_ovf[k] = m_sum[k] > MAXV;
            m_sum[k] = 0; m_cnt[k] = 0;
          end
        end
      end
    end
    started = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("out_valid[%0d]", k), {31'd0, ov[k]}, {31'd0, m_ov[k]});
      chk($sformatf("out_data[%0d]", k), {20'd0, dat[k]}, m_dat[k]);
      chk($sformatf("out_ovf[%0d]", k), {31'd0, ovf[k]}, {31'd0, m_ovf[k]});
    end
  endtask

  initial begin
    // reset state
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    chk("rst_valid", {31'd0, ov[0]}, 0);
    chk("rst_data", {20'd0, dat[0]}, 0);
    chk("rst_ready", {31'd0, rdy[0]}, 1);

    // four beats of 10+5
    for (int i = 0; i < 4; i++) cycle(1, 10, 5, 0, 1, 1);
    chk("tp1_valid", {31'd0, ov[0]}, 1);
    chk("tp1_data", {20'd0, dat[0]}, 60);
    chk("tp1_ovf", {31'd0, ovf[0]}, 0);
    cycle(0, 0, 0, 0, 1, 1);
    chk("tp1_drop", {31'd0, ov[0]}, 0);

    // completion held under backpressure, then next block of 1+1 beats
    for (int i = 0; i < 4; i++) cycle(1, 10, 5, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 1, 0, 0, 1);
      chk("tp2_hold", {20'd0, dat[0]}, 60);
      chk("tp2_stall", {31'd0, rdy[0]}, 0);
    end
    for (int i = 0; i < 4; i++) cycle(1, 1, 1, 0, 1, 1);
    chk("tp2_next", {20'd0, dat[0]}, 8);

    // max-value beats: 4 -> 4088, 5 -> overflow
    cycle(0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 4; i++) cycle(1, 511, 511, 0, 1, 1);
    chk("tp3_data4", {20'd0, dat[0]}, 4088);
    chk("tp3_ovf4", {31'd0, ovf[0]}, 0);
    cycle(1, 511, 511, 0, 1, 1);
`ifdef SUM_ACCUM_SAT_EN
    chk("tp3_data5", {20'd0, dat[1]}, 4095);
`else
    chk("tp3_data5", {20'd0, dat[1]}, 1014);
`endif
    chk("tp3_ovf5", {31'd0, ovf[1]}, 1);

    // clr discards partial block and its own beat
    cycle(0, 0, 0, 1, 1, 1);
    cycle(1, 3, 4, 0, 1, 1);
    cycle(1, 3, 4, 0, 1, 1);
    cycle(1, 3, 4, 1, 1, 1);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 1, 1);
    chk("tp4_data", {20'd0, dat[0]}, 4);

    // single-sample instance streams back-to-back
    for (int i = 1; i <= 6; i++) begin
      cycle(1, i, 0, 0, 1, 1);
      chk("tp5_valid", {31'd0, ov[2]}, 1);
      chk("tp5_data", {20'd0, dat[2]}, i);
    end
    for (int i = 7; i < 20; i++) cycle(1, i, 0, 0, (i % 3) != 0, 1);

    // reset mid-block while results are pending
    cycle(0, 0, 0, 1, 1, 1);
    cycle(1, 1, 1, 0, 1, 1);
    cycle(1, 1, 1, 0, 1, 1);
    cycle(0, 0, 0, 0, 0, 0);
    chk("tp6_valid", {31'd0, ov[2]}, 0);
    chk("tp6_data", {20'd0, dat[2]}, 0);
    for (int i = 0; i < 4; i++) cycle(1, 2, 1, 0, 1, 1);
    chk("tp6_sum", {20'd0, dat[0]}, 12);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(3) != 0, $urandom_range(511), $urandom_range(511),
            $urandom_range(31) == 0, $urandom_range(3) != 0, $urandom_range(127) != 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
